// File: rtl/lau_pkg.sv
// Shared types for the accumulator/adder library: adder speed grade and accumulator FSM states.
package lau_pkg;

   typedef enum logic {
      SLOW,
      FAST
   } speed_e;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      OUT
   } cpr_accu_state_e;

endpackage

// File: rtl/cpr_row.sv
// ACCW columns of (NIN,2)-compressors built from NIN-2 chained full adders per column;
// the NIN-3 intermediate carries of column i feed column i+1, column 0 sees zero.
module cpr_row #(
   parameter int ACCW = 16,
   parameter int NIN  = 6
) (
   input  logic [NIN*ACCW-1:0] in_i,
   output logic [ACCW-1:0]     sum_o,
   output logic [ACCW-1:0]     carry_o
);

   logic [NIN-3:0] w_co;
   logic [NIN-4:0] w_ci;
   logic           w_t;
   logic           w_b;
   logic           w_x;

   // Full adder j of a column takes the running sum, input j+2 and carry-in j-1;
   // its carry-out j goes to adder j+1 of the next column, the last one is C.
   always_comb begin
      sum_o   = '0;
      carry_o = '0;
      w_ci    = '0;
      w_co    = '0;
      w_t     = 1'b0;
      w_b     = 1'b0;
      w_x     = 1'b0;
      for (int i = 0; i < ACCW; i++) begin
         w_co    = '0;
         w_t     = in_i[i];
         w_b     = in_i[ACCW + i];
         w_x     = in_i[2*ACCW + i];
         w_co[0] = (w_t & w_b) | (w_t & w_x) | (w_b & w_x);
         w_t     = w_t ^ w_b ^ w_x;
         for (int j = 1; j < NIN - 2; j++) begin
            w_b     = in_i[(j+2)*ACCW + i];
            w_x     = w_ci[j-1];
            w_co[j] = (w_t & w_b) | (w_t & w_x) | (w_b & w_x);
            w_t     = w_t ^ w_b ^ w_x;
         end
         sum_o[i]   = w_t;
         carry_o[i] = w_co[NIN-3];
         w_ci       = w_co[NIN-4:0];
      end
   end

endmodule

// File: rtl/lau_adder.sv
// WIDTH-bit carry-propagate adder, result modulo 2^WIDTH; combinational.
// SLOW selects a ripple chain, FAST a Kogge-Stone parallel-prefix carry network.
module lau_adder
   import lau_pkg::*;
#(
   parameter int     WIDTH = 16,
   parameter speed_e SPEED = FAST
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] sum_o
);

   if (SPEED == FAST) begin : g_fast
      logic [WIDTH-1:0] w_g;
      logic [WIDTH-1:0] w_p;
      logic [WIDTH-1:0] w_c;

      // Descending i keeps w_g[i-d]/w_p[i-d] at the previous level's value.
      always_comb begin
         w_g = a_i & b_i;
         w_p = a_i ^ b_i;
         for (int d = 1; d < WIDTH; d = d * 2) begin
            for (int i = WIDTH - 1; i >= d; i--) begin
               w_g[i] = w_g[i] | (w_p[i] & w_g[i-d]);
               w_p[i] = w_p[i] & w_p[i-d];
            end
         end
         w_c   = WIDTH'({w_g, 1'b0});
         sum_o = a_i ^ b_i ^ w_c;
      end
   end else begin : g_slow
      logic w_rc;

      always_comb begin
         w_rc  = 1'b0;
         sum_o = '0;
         for (int i = 0; i < WIDTH; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ w_rc;
            w_rc     = (a_i[i] & b_i[i]) | (a_i[i] & w_rc) | (b_i[i] & w_rc);
         end
      end
   end

endmodule

// File: rtl/cpr_accu.sv
// Streams NOPS-operand beats into a carry-save sum/carry pair; one CPA resolves the packet total.
// Result valid the cycle after the last beat; input stalls while the result waits for out_ready_i.
module cpr_accu
   import lau_pkg::*;
#(
   parameter int     WIDTH  = 8,
   parameter int     NOPS   = 4,
   parameter int     ACCW   = 16,
   parameter int     CNTW   = 8,
   parameter int     SIGNED = 0,
   parameter speed_e SPEED  = FAST
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [NOPS*WIDTH-1:0] in_ops_i,
   input  logic                  in_last_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [ACCW-1:0]       out_sum_o,
   output logic [CNTW-1:0]       out_cnt_o
);

   localparam int NIN = NOPS + 2;

   cpr_accu_state_e        r_state;
   logic [ACCW-1:0]        r_sum;
   logic [ACCW-1:0]        r_carry;
   logic [CNTW-1:0]        r_cnt;

   logic [NIN*ACCW-1:0]    w_row_in;
   logic [WIDTH-1:0]       w_op;
   logic [ACCW-1:0]        w_s;
   logic [ACCW-1:0]        w_c;
   logic [ACCW-1:0]        w_total;
   logic                   w_accept;

   always_comb begin
      w_row_in = '0;
      w_op     = '0;
      for (int k = 0; k < NOPS; k++) begin
         w_op = in_ops_i[k*WIDTH +: WIDTH];
         if (SIGNED != 0) begin
            w_row_in[k*ACCW +: ACCW] = ACCW'($signed(w_op));
         end else begin
            w_row_in[k*ACCW +: ACCW] = ACCW'(w_op);
         end
      end
      w_row_in[NOPS*ACCW +: ACCW]     = r_sum;
      w_row_in[(NOPS+1)*ACCW +: ACCW] = r_carry;
   end

   cpr_row #(
      .ACCW (ACCW),
      .NIN  (NIN)
   ) u_row (
      .in_i    (w_row_in),
      .sum_o   (w_s),
      .carry_o (w_c)
   );

   lau_adder #(
      .WIDTH (ACCW),
      .SPEED (SPEED)
   ) u_cpa (
      .a_i   (r_sum),
      .b_i   (r_carry),
      .sum_o (w_total)
   );

   assign w_accept = in_valid_i & (r_state != OUT);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_sum   <= '0;
         r_carry <= '0;
         r_cnt   <= '0;
      end else if (clr_i) begin
         r_state <= IDLE;
         r_sum   <= '0;
         r_carry <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE, ACC: begin
               if (w_accept) begin
                  r_sum   <= w_s;
                  // Carry column i weighs 2^(i+1); the carry out of the top column is dropped.
                  r_carry <= ACCW'({w_c, 1'b0});
                  r_cnt   <= (r_cnt == {CNTW{1'b1}}) ? r_cnt : r_cnt + CNTW'(1);
                  r_state <= in_last_i ? OUT : ACC;
               end
            end
            OUT: begin
               if (out_ready_i) begin
                  r_state <= IDLE;
                  r_sum   <= '0;
                  r_carry <= '0;
                  r_cnt   <= '0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready_o  = (r_state != OUT);
   assign out_valid_o = (r_state == OUT);
   assign out_sum_o   = (r_state == OUT) ? w_total : '0;
   assign out_cnt_o   = (r_state == OUT) ? r_cnt : '0;

endmodule
